// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: default width, FSM
// encoding and Booth window codes used by the datapath and the control model.
package mult_pkg;

   localparam int WIDTH = 32;
   localparam int ITERS = WIDTH / 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] BW_NOP_0   = 3'b000;
   localparam logic [2:0] BW_ADD_M_0 = 3'b001;
   localparam logic [2:0] BW_ADD_M_1 = 3'b010;
   localparam logic [2:0] BW_ADD_2M  = 3'b011;
   localparam logic [2:0] BW_SUB_2M  = 3'b100;
   localparam logic [2:0] BW_SUB_M_0 = 3'b101;
   localparam logic [2:0] BW_SUB_M_1 = 3'b110;
   localparam logic [2:0] BW_NOP_1   = 3'b111;

   typedef struct packed {
      logic add;
      logic sub;
      logic shift_mcand;
   } booth_cmd_t;

   // Window-to-command mapping the control unit is expected to apply.
   function automatic booth_cmd_t booth_decode(input logic [2:0] window);
      booth_cmd_t cmd;
      cmd = '0;
      case (window)
         BW_ADD_M_0, BW_ADD_M_1: cmd.add = 1'b1;
         BW_ADD_2M: begin
            cmd.add         = 1'b1;
            cmd.shift_mcand = 1'b1;
         end
         BW_SUB_2M: begin
            cmd.sub         = 1'b1;
            cmd.shift_mcand = 1'b1;
         end
         BW_SUB_M_0, BW_SUB_M_1: cmd.sub = 1'b1;
         default: cmd = '0;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/booth_addend_sel.sv
// Combinational Booth addend: sign-extends M to WIDTH+2 bits, optionally
// doubles it and optionally negates it (two's complement).
module booth_addend_sel
   import mult_pkg::*;
#(
   parameter int WIDTH = mult_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] mcand,
   input  logic             shift_mcand,
   input  logic             negate,
   output logic [WIDTH+1:0] addend
);

   genvar gi;

   logic [WIDTH+1:0] mcand_ext;
   logic [WIDTH+1:0] magnitude;

   assign mcand_ext[WIDTH-1:0] = mcand;
   for (gi = WIDTH; gi < WIDTH + 2; gi++) begin : g_sext
      assign mcand_ext[gi] = mcand[WIDTH-1];
   end

   // Two guard bits keep -2*min_int and +2*max_int representable.
   assign magnitude = shift_mcand ? {mcand_ext[WIDTH:0], 1'b0} : mcand_ext;
   assign addend    = negate ? (~magnitude + 1'b1) : magnitude;

endmodule

// File: rtl/booth_mult_datapath.sv
// Radix-4 Booth multiplier datapath driven by an external control unit.
// Define MULT_OVF_EN to compute the overflow flag; otherwise it is tied low.
module booth_mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = mult_pkg::WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic             ctrl_add,
   input  logic             ctrl_sub,
   input  logic             ctrl_shift_mcand,
   input  logic             ctrl_shift_product,
   input  logic             ctrl_nop,
   output logic [2:0]       booth_bits,
   output logic             ctrl_start,
   output logic [WIDTH-1:0] product,
   output logic             overflow,
   output logic             result_valid
);

   localparam int N_ITERS = WIDTH / 2;
   localparam int CNT_W   = $clog2(N_ITERS) + 1;
   localparam int PW      = 2 * WIDTH + 3;
   localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(N_ITERS);

   genvar gi;

   state_t           state_reg, state_next;
   logic [PW-1:0]    p_reg, p_next;
   logic [WIDTH-1:0] m_reg, m_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] product_reg, product_next;
   logic             overflow_reg, overflow_next;
   logic             valid_reg, valid_next;
   logic             ctrl_start_reg, ctrl_start_next;

   logic [WIDTH+1:0] acc_cur;
   logic [WIDTH+1:0] acc_new;
   logic [WIDTH+1:0] addend;
   logic             do_acc;
   logic [PW-1:0]    p_acc;
   logic [PW-1:0]    p_shift;
   logic [CNT_W-1:0] count_inc;
   logic             ovf_calc;

   booth_addend_sel #(
      .WIDTH (WIDTH)
   ) u_addend_sel (
      .mcand       (m_reg),
      .shift_mcand (ctrl_shift_mcand),
      .negate      (ctrl_sub),
      .addend      (addend)
   );

   // add+sub together is an illegal command and collapses to a nop.
   assign acc_cur   = p_reg[PW-1:WIDTH+1];
   assign do_acc    = (ctrl_add ^ ctrl_sub) & ~ctrl_nop;
   assign acc_new   = do_acc ? (acc_cur + addend) : acc_cur;
   assign p_acc     = {acc_new, p_reg[WIDTH:0]};
   assign p_shift   = {{2{p_acc[PW-1]}}, p_acc[PW-1:2]};
   assign count_inc = count_reg + 1'b1;

`ifdef MULT_OVF_EN
   logic [WIDTH+2:0] ovf_bits;
   for (gi = 0; gi < WIDTH + 3; gi++) begin : g_ovf
      assign ovf_bits[gi] = p_shift[WIDTH+gi] ^ p_shift[WIDTH];
   end
   assign ovf_calc = |ovf_bits;
`else
   assign ovf_calc = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      p_next          = p_reg;
      m_next          = m_reg;
      count_next      = count_reg;
      product_next    = product_reg;
      overflow_next   = overflow_reg;
      valid_next      = valid_reg;
      ctrl_start_next = 1'b0;

      if (start) begin
         m_next          = multiplicand;
         p_next          = {{(WIDTH+2){1'b0}}, multiplier, 1'b0};
         count_next      = '0;
         product_next    = '0;
         overflow_next   = 1'b0;
         valid_next      = 1'b0;
         ctrl_start_next = 1'b1;
         state_next      = RUN;
      end else if (state_reg == RUN) begin
         if (ctrl_shift_product) begin
            p_next     = p_shift;
            count_next = count_inc;
            if (count_inc == ITERS_C) begin
               product_next  = p_shift[WIDTH:1];
               overflow_next = ovf_calc;
               valid_next    = 1'b1;
               state_next    = DONE;
            end
         end else begin
            p_next = p_acc;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         p_reg          <= '0;
         m_reg          <= '0;
         count_reg      <= '0;
         product_reg    <= '0;
         overflow_reg   <= 1'b0;
         valid_reg      <= 1'b0;
         ctrl_start_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         p_reg          <= p_next;
         m_reg          <= m_next;
         count_reg      <= count_next;
         product_reg    <= product_next;
         overflow_reg   <= overflow_next;
         valid_reg      <= valid_next;
         ctrl_start_reg <= ctrl_start_next;
      end
   end

   assign booth_bits   = p_reg[2:0];
   assign ctrl_start   = ctrl_start_reg;
   assign product      = product_reg;
   assign overflow     = overflow_reg;
   assign result_valid = valid_reg;

endmodule
